// File: rtl/ddr_mem_tester_if.sv
// MIG user-interface (app_*) command, write-data and read-data channels.
// master = traffic generator, slave = memory controller.
interface ddr_mem_tester_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr_mem_tester.sv
// Self-checking DDR3 traffic generator: writes address-derived bursts through the MIG
// app interface, reads them back in order and reports pass/fail, error count and first bad address.
module ddr_mem_tester #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDR_INC       = 8,
  parameter int unsigned NUM_BURSTS     = 1024,
  parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  init_calib_complete,
  ddr_mem_tester_if.master      app,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned IW = $clog2(NUM_BURSTS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_INC);

  typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         chk_idx;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  cmd_done;
  logic                  dat_done;
  logic [TW-1:0]         idle_cnt;

  logic                  cmd_acc;
  logic                  dat_acc;
  logic                  rd_valid;
  logic                  mismatch;
  logic                  progress;
  logic                  expired;
  logic                  retire;
  logic [15:0]           err_next;

  // Expected burst content: the 28-bit burst address in each 32-bit lane, XORed with the seed.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] word;
    word = {4'h0, 28'(a)} ^ SEED;
    return DATA_WIDTH'({4{word}});
  endfunction

  assign app.app_wdf_end = app.app_wdf_wren;

  assign cmd_acc  = app.app_en & app.app_rdy;
  assign dat_acc  = app.app_wdf_wren & app.app_wdf_rdy;
  assign rd_valid = (state == READ) & app.app_rd_data_valid;
  assign mismatch = rd_valid & (app.app_rd_data != pattern(chk_addr));
  assign progress = cmd_acc | dat_acc | rd_valid;
  assign expired  = ((state == WRITE) | (state == READ)) & ~progress &
                    (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  // A write burst retires once command and data have each been accepted, in any order.
  assign retire   = (cmd_done | cmd_acc) & (dat_done | dat_acc);
  assign err_next = (mismatch && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wr_idx           <= '0;
      rd_idx           <= '0;
      chk_idx          <= '0;
      chk_addr         <= '0;
      cmd_done         <= 1'b0;
      dat_done         <= 1'b0;
      idle_cnt         <= '0;
      app.app_addr     <= '0;
      app.app_cmd      <= CMD_WR;
      app.app_en       <= 1'b0;
      app.app_wdf_data <= '0;
      app.app_wdf_wren <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      error_count      <= '0;
      first_err_addr   <= '0;
    end else begin
      if (state == WRITE || state == READ) begin
        idle_cnt <= progress ? '0 : idle_cnt + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WAIT_CAL;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
          end
        end

        WAIT_CAL: begin
          if (init_calib_complete) begin
            state            <= WRITE;
            wr_idx           <= '0;
            cmd_done         <= 1'b0;
            dat_done         <= 1'b0;
            idle_cnt         <= '0;
            app.app_cmd      <= CMD_WR;
            app.app_addr     <= '0;
            app.app_wdf_data <= pattern('0);
            app.app_en       <= 1'b1;
            app.app_wdf_wren <= 1'b1;
          end
        end

        WRITE: begin
          if (expired) begin
            state            <= DONE;
            app.app_en       <= 1'b0;
            app.app_wdf_wren <= 1'b0;
            timeout          <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b1;
            pass             <= 1'b0;
          end else begin
            if (cmd_acc) begin
              app.app_en <= 1'b0;
              cmd_done   <= 1'b1;
            end
            if (dat_acc) begin
              app.app_wdf_wren <= 1'b0;
              dat_done         <= 1'b1;
            end
            if (retire) begin
              cmd_done <= 1'b0;
              dat_done <= 1'b0;
              if (wr_idx == LAST_IDX) begin
                state        <= READ;
                rd_idx       <= '0;
                chk_idx      <= '0;
                chk_addr     <= '0;
                app.app_cmd  <= CMD_RD;
                app.app_addr <= '0;
                app.app_en   <= 1'b1;
              end else begin
                wr_idx           <= wr_idx + 1'b1;
                app.app_addr     <= app.app_addr + STEP;
                app.app_wdf_data <= pattern(app.app_addr + STEP);
                app.app_en       <= 1'b1;
                app.app_wdf_wren <= 1'b1;
              end
            end
          end
        end

        READ: begin
          if (expired) begin
            state      <= DONE;
            app.app_en <= 1'b0;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
          end else begin
            if (cmd_acc) begin
              rd_idx       <= rd_idx + 1'b1;
              app.app_addr <= app.app_addr + STEP;
              if (rd_idx == LAST_IDX) app.app_en <= 1'b0;
            end
            // Read data returns in command order, so chk_addr tracks the beat's address.
            if (rd_valid) begin
              chk_idx     <= chk_idx + 1'b1;
              chk_addr    <= chk_addr + STEP;
              error_count <= err_next;
              if (mismatch && error_count == 16'd0) first_err_addr <= chk_addr;
              if (chk_idx == LAST_IDX) begin
                state      <= DONE;
                app.app_en <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= (err_next == 16'd0);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_mem_tester.sv
// Bench for ddr_mem_tester: behavioural MIG memory model (queued commands, fixed read latency,
// optional stalls/corruption/no-return) plus a scoreboard of everything the tester wrote and read.
module tb_ddr_mem_tester;

  localparam int unsigned NB     = 16;
  localparam int unsigned INC    = 8;
  localparam int unsigned TO     = 100;
  localparam int unsigned RD_LAT = 20;
  localparam int unsigned BOUND  = 5000;
  localparam logic [31:0] SEED   = 32'hA5A5_5A5A;

  typedef struct {
    int unsigned addr;
    int unsigned due;
  } rd_req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        init_calib_complete = 1'b1;
  logic        busy, done, pass, timeout;
  logic [15:0] error_count;
  logic [27:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  // Memory-model state and scoreboard
  bit           stall_en = 1'b0;
  bit           no_read  = 1'b0;
  logic [127:0] mem [int unsigned];
  logic [127:0] corrupt [int unsigned];
  int unsigned  wr_log[$];
  int unsigned  rd_log[$];
  int unsigned  wq_addr[$];
  logic [127:0] wq_data[$];
  rd_req_t      rq[$];
  int unsigned  inj_count = 0;
  int unsigned  inj_first = 0;
  int unsigned  bad_cmd = 0;
  int unsigned  bad_end = 0;
  int unsigned  cyc = 0;

  ddr_mem_tester_if #(.ADDR_WIDTH(28), .DATA_WIDTH(128)) bus ();

  ddr_mem_tester #(
    .ADDR_WIDTH(28), .DATA_WIDTH(128), .ADDR_INC(INC), .NUM_BURSTS(NB),
    .SEED(SEED), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .init_calib_complete(init_calib_complete),
    .app(bus),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .error_count(error_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_pattern(input int unsigned a);
    logic [127:0] p;
    for (int lane = 0; lane < 4; lane++) p[lane*32 +: 32] = (a & 32'h0FFF_FFFF) ^ SEED;
    return p;
  endfunction

  // Number of bursts not written exactly once, in order, with the expected pattern.
  function automatic int wr_bad();
    int n = 0;
    if (wr_log.size() != NB) n++;
    for (int i = 0; i < NB; i++) begin
      int unsigned a = i * INC;
      if (i >= wr_log.size() || wr_log[i] != a) n++;
      else if (!mem.exists(a) || mem[a] !== exp_pattern(a)) n++;
    end
    return n;
  endfunction

  function automatic int rd_bad();
    int n = 0;
    if (rd_log.size() != NB) n++;
    for (int i = 0; i < NB; i++)
      if (i >= rd_log.size() || rd_log[i] != i * INC) n++;
    return n;
  endfunction

  // Memory model: everything happens at negedge; handshakes land on the following posedge.
  initial begin
    rd_req_t      r;
    int unsigned  a;
    logic [127:0] d;
    bus.app_rdy           = 1'b1;
    bus.app_wdf_rdy       = 1'b1;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.app_rd_data_valid = 1'b0;
      if (reset) begin
        wq_addr.delete();
        wq_data.delete();
        rq.delete();
      end else begin
        bus.app_rdy     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.app_wdf_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.app_en && bus.app_rdy) begin
          a = 32'(bus.app_addr);
          if (bus.app_cmd == 3'b000) begin
            wq_addr.push_back(a);
            wr_log.push_back(a);
          end else if (bus.app_cmd == 3'b001) begin
            rq.push_back('{a, cyc + RD_LAT});
            rd_log.push_back(a);
          end else bad_cmd++;
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
          wq_data.push_back(bus.app_wdf_data);
          if (bus.app_wdf_end !== 1'b1) bad_end++;
        end
        while (wq_addr.size() > 0 && wq_data.size() > 0) begin
          mem[wq_addr[0]] = wq_data[0];
          void'(wq_addr.pop_front());
          void'(wq_data.pop_front());
        end
        if (!no_read && rq.size() > 0 && rq[0].due <= cyc) begin
          r = rq.pop_front();
          d = mem.exists(r.addr) ? mem[r.addr] : '0;
          if (corrupt.exists(r.addr)) begin
            d ^= corrupt[r.addr];
            if (inj_count == 0) inj_first = r.addr;
            inj_count++;
          end
          bus.app_rd_data       = d;
          bus.app_rd_data_valid = 1'b1;
        end
      end
    end
  end

  task automatic clear_model();
    mem.delete();
    wr_log.delete();
    rd_log.delete();
    wq_addr.delete();
    wq_data.delete();
    rq.delete();
    inj_count = 0;
    inj_first = 0;
    bad_cmd   = 0;
    bad_end   = 0;
  endtask

  task automatic run_pass(output bit ok);
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: busy/done/pass/timeout=%b required 0000", {busy, done, pass, timeout});
    end
    checks++;
    if (error_count !== 16'd0 || first_err_addr !== 28'd0) begin
      errors++; $display("FAIL reset_counts: error_count=%0d first_err_addr=%h required 0/0", error_count, first_err_addr);
    end
    checks++;
    if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end} !== 3'b000 || bus.app_cmd !== 3'b000 || bus.app_addr !== 28'd0) begin
      errors++; $display("FAIL reset_bus: en=%b wren=%b end=%b cmd=%b addr=%h required all 0",
                         bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.app_cmd, bus.app_addr);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.app_en !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: busy=%b app_en=%b required 0/0 without start", busy, bus.app_en);
    end
  endtask

  task automatic test_ideal();
    bit ok;
    clear_model();
    run_pass(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ideal_done: done=%b required 1 within %0d cycles", done, BOUND); end
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ideal_status: pass=%b timeout=%b busy=%b required 1/0/0", pass, timeout, busy);
    end
    checks++;
    if (error_count !== 16'd0 || first_err_addr !== 28'd0) begin
      errors++; $display("FAIL ideal_counts: error_count=%0d first_err_addr=%h required 0/0", error_count, first_err_addr);
    end
    checks++;
    if (wr_bad() != 0) begin errors++; $display("FAIL ideal_writes: %0d bad write entries (log size %0d) required 0", wr_bad(), wr_log.size()); end
    checks++;
    if (rd_bad() != 0) begin errors++; $display("FAIL ideal_reads: %0d bad read entries (log size %0d) required 0", rd_bad(), rd_log.size()); end
    checks++;
    if (bad_cmd != 0 || bad_end != 0) begin errors++; $display("FAIL ideal_protocol: bad_cmd=%0d bad_end=%0d required 0/0", bad_cmd, bad_end); end
  endtask

  task automatic test_corrupt();
    bit ok;
    clear_model();
    corrupt.delete();
    corrupt[32'h28] = 128'd1;
    run_pass(ok);
    checks++;
    if (!ok || pass !== 1'b0) begin errors++; $display("FAIL corrupt_status: done=%b pass=%b required 1/0", done, pass); end
    checks++;
    if (error_count !== 16'd1) begin errors++; $display("FAIL corrupt_count: error_count=%0d required 1", error_count); end
    checks++;
    if (first_err_addr !== 28'h28) begin errors++; $display("FAIL corrupt_addr: first_err_addr=%h required 028", first_err_addr); end
    // Several random corruptions at random bit positions; model counts what it injected.
    corrupt.delete();
    for (int k = 0; k < 3; k++) begin
      int unsigned b = $urandom_range(0, NB - 1);
      logic [127:0] m = 128'd1 << $urandom_range(0, 127);
      corrupt[b * INC] = m;
    end
    clear_model();
    run_pass(ok);
    checks++;
    if (!ok || pass !== 1'b0 || 32'(error_count) != inj_count) begin
      errors++; $display("FAIL rand_corrupt_count: done=%b pass=%b error_count=%0d required done=1 pass=0 count=%0d",
                         done, pass, error_count, inj_count);
    end
    checks++;
    if (32'(first_err_addr) != inj_first) begin
      errors++; $display("FAIL rand_corrupt_addr: first_err_addr=%h required %h", first_err_addr, inj_first);
    end
    corrupt.delete();
  endtask

  task automatic test_stalls();
    bit ok;
    for (int rep = 0; rep < 2; rep++) begin
      clear_model();
      stall_en = 1'b1;
      run_pass(ok);
      stall_en = 1'b0;
      checks++;
      if (!ok || pass !== 1'b1 || timeout !== 1'b0) begin
        errors++; $display("FAIL stall_status[%0d]: done=%b pass=%b timeout=%b required 1/1/0", rep, done, pass, timeout);
      end
      checks++;
      if (wr_bad() != 0) begin errors++; $display("FAIL stall_writes[%0d]: %0d bad write entries required 0", rep, wr_bad()); end
      checks++;
      if (rd_bad() != 0 || bad_cmd != 0 || bad_end != 0) begin
        errors++; $display("FAIL stall_reads[%0d]: bad reads=%0d bad_cmd=%0d bad_end=%0d required 0", rep, rd_bad(), bad_cmd, bad_end);
      end
    end
  endtask

  task automatic test_calib();
    int en_seen = 0;
    int busy_low = 0;
    int n = 0;
    clear_model();
    init_calib_complete = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) en_seen++;
      if (busy !== 1'b1) busy_low++;
    end
    checks++;
    if (en_seen != 0 || busy_low != 0) begin
      errors++; $display("FAIL calib_hold: strobe cycles=%0d busy-low cycles=%0d required 0/0", en_seen, busy_low);
    end
    init_calib_complete = 1'b1;
    while (done !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || wr_bad() != 0 || rd_bad() != 0) begin
      errors++; $display("FAIL calib_pass: done=%b pass=%b bad writes=%0d bad reads=%0d required 1/1/0/0", done, pass, wr_bad(), rd_bad());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int en_seen = 0;
    clear_model();
    no_read = 1'b1;
    run_pass(ok);
    checks++;
    if (!ok || timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_status: done=%b timeout=%b pass=%b busy=%b required 1/1/0/0", done, timeout, pass, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0 || done !== 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin errors++; $display("FAIL timeout_quiet: %0d cycles with strobes or done low, required 0", en_seen); end
    checks++;
    if (wr_bad() != 0 || rd_log.size() != NB) begin
      errors++; $display("FAIL timeout_traffic: bad writes=%0d reads issued=%0d required 0/%0d", wr_bad(), rd_log.size(), NB);
    end
    no_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bit ok;
    clear_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || wr_bad() != 0 || rd_bad() != 0) begin
      errors++; $display("FAIL busy_start: done=%b pass=%b writes=%0d reads=%0d required 1/1/%0d/%0d",
                         done, pass, wr_log.size(), rd_log.size(), NB, NB);
    end
    clear_model();
    run_pass(ok);
    checks++;
    if (!ok || pass !== 1'b1 || wr_bad() != 0 || rd_bad() != 0) begin
      errors++; $display("FAIL restart_from_done: done=%b pass=%b bad writes=%0d bad reads=%0d required 1/1/0/0",
                         done, pass, wr_bad(), rd_bad());
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    bit ok;
    clear_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (rd_log.size() < 4 && n < BOUND) begin @(negedge clk); n++; end
    checks++;
    if (rd_log.size() < 4) begin errors++; $display("FAIL midread_reach: reads issued=%0d required >=4", rd_log.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, timeout, bus.app_en, bus.app_wdf_wren} !== 6'b0 || bus.app_cmd !== 3'b000 ||
        bus.app_addr !== 28'd0 || error_count !== 16'd0 || first_err_addr !== 28'd0) begin
      errors++; $display("FAIL midread_reset: busy=%b done=%b en=%b wren=%b cmd=%b addr=%h cnt=%0d required all 0",
                         busy, done, bus.app_en, bus.app_wdf_wren, bus.app_cmd, bus.app_addr, error_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.app_en !== 1'b0) begin
      errors++; $display("FAIL midread_idle: busy=%b done=%b app_en=%b required 0/0/0", busy, done, bus.app_en);
    end
    clear_model();
    run_pass(ok);
    checks++;
    if (!ok || pass !== 1'b1 || error_count !== 16'd0 || wr_bad() != 0 || rd_bad() != 0) begin
      errors++; $display("FAIL midread_recover: done=%b pass=%b error_count=%0d bad writes=%0d bad reads=%0d required 1/1/0/0/0",
                         done, pass, error_count, wr_bad(), rd_bad());
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt();
    test_stalls();
    test_calib();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
